// File: rtl/mem_stage_responder.sv
// MEM-stage responder: accepts an LW/SW from EX/MEM, services it against a
// word-wide data memory after LATENCY busy cycles, then pulses resp_valid_o.
module mem_stage_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [15:0] resp_rdata_o,
  output logic        misaligned_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic                  wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [15:0]           wdata;
    logic                  mis;
  } req_t;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [15:0] rdata_q;
  logic        access;

  logic [15:0] mem [2**DEPTH_LOG2];

  // Upper address bits are deliberately dropped so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^req_addr_i;

  assign access = (state_q == S_BUSY) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = req_valid_i;
        if (req_valid_i) begin
          req_d.wr    = req_wr_i;
          req_d.idx   = req_addr_i[DEPTH_LOG2:1];
          req_d.wdata = req_wdata_i;
          req_d.mis   = req_addr_i[0];
          cnt_d       = 4'(LATENCY - 1);
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      if (access && !req_q.wr) rdata_q <= mem[req_q.idx];
    end
  end

  // Memory is never cleared; a reset edge suppresses an in-flight store.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && access && req_q.wr) mem[req_q.idx] <= req_q.wdata;
  end

  assign resp_valid_o = (state_q == S_DONE);
  assign misaligned_o = (state_q == S_DONE) && req_q.mis;
  assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Bench for mem_stage_responder: LATENCY=4 instance driven from a vector table,
// LATENCY=1 instance for back-to-back held requests, plus a mid-access reset.
module tb_mem_stage_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv_a = 1'b0, rv_b = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
  logic        stall_a, resp_a, mis_a, stall_b, resp_b, mis_b;
  logic [15:0] rdata_a, rdata_b;
  int          sel = 0;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  mem_stage_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(rv_a), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .stall_o(stall_a),
    .resp_valid_o(resp_a), .resp_rdata_o(rdata_a), .misaligned_o(mis_a));

  mem_stage_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(rv_b), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .stall_o(stall_b),
    .resp_valid_o(resp_b), .resp_rdata_o(rdata_b), .misaligned_o(mis_b));

  logic        st_m, rv_m, mis_m;
  logic [15:0] rd_m;
  assign st_m  = (sel != 0) ? stall_b : stall_a;
  assign rv_m  = (sel != 0) ? resp_b  : resp_a;
  assign mis_m = (sel != 0) ? mis_b   : mis_a;
  assign rd_m  = (sel != 0) ? rdata_b : rdata_a;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          exp_mis;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    bit          mis;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drives one request starting just after a rising edge; leaves req_valid high
  // so the caller may chain the next request back-to-back.
  task automatic run_req(input int s, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rdata,
                         input bit exp_mis);
    int   lat;
    exp_t e;
    lat = (s != 0) ? 1 : 4;
    sel = s;
    req_wr = wr; req_addr = addr; req_wdata = wdata;
    if (s != 0) rv_b = 1'b1; else rv_a = 1'b1;
    sb.push_back('{exp_rdata, exp_mis});
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk("stall_busy", st_m, 1'b1);
      chk("resp_valid_busy", rv_m, 1'b0);
      chk("misaligned_busy", mis_m, 1'b0);
      @(posedge clk); #1;
      if (c < lat) begin
        req_wr = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      end
    end
    @(negedge clk);
    chk("stall_done", st_m, 1'b0);
    chk("resp_valid_done", rv_m, 1'b1);
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: response with empty queue");
    end else begin
      e = sb.pop_front();
      chk("resp_rdata", rd_m, e.rdata);
      chk("misaligned", mis_m, 16'(e.mis));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input int s, input int n, input logic [15:0] exp_rdata);
    sel = s;
    rv_a = 1'b0; rv_b = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_stall", st_m, 1'b0);
      chk("idle_resp_valid", rv_m, 1'b0);
      chk("idle_rdata_hold", rd_m, exp_rdata);
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0},
      '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0},
      '{1'b1, 16'h0021, 16'h1234, 16'hBEEF, 1'b1},
      '{1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0},
      '{1'b1, 16'h0802, 16'hA5A5, 16'h1234, 1'b0},
      '{1'b0, 16'h0002, 16'h0000, 16'hA5A5, 1'b0},
      '{1'b1, 16'h0040, 16'h1111, 16'hA5A5, 1'b0},
      '{1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b1}
    };

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stall", stall_a, 1'b0);
    chk("rst_resp_valid", resp_a, 1'b0);
    chk("rst_rdata", rdata_a, 16'h0000);
    chk("rst_misaligned", mis_a, 1'b0);
    @(posedge clk); #1;

    foreach (vecs[i])
      run_req(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_mis);
    idle_chk(0, 2, 16'hBEEF);

    // Reset lands at the end of cycle 2 of a store; the store must not happen.
    sel = 0;
    req_wr = 1'b1; req_addr = 16'h0040; req_wdata = 16'h5555; rv_a = 1'b1;
    @(negedge clk); chk("mid_rst_c0_stall", stall_a, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); chk("mid_rst_c1_stall", stall_a, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; rv_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_stall", stall_a, 1'b0);
    chk("mid_rst_resp_valid", resp_a, 1'b0);
    chk("mid_rst_rdata", rdata_a, 16'h0000);
    chk("mid_rst_misaligned", mis_a, 1'b0);
    @(posedge clk); #1;
    run_req(0, 1'b0, 16'h0040, 16'h0000, 16'h1111, 1'b0);
    idle_chk(0, 1, 16'h1111);

    // LATENCY=1: req_valid held through DONE and into the next cycle.
    run_req(1, 1'b1, 16'h0006, 16'h7777, 16'h0000, 1'b0);
    run_req(1, 1'b0, 16'h0006, 16'h0000, 16'h7777, 1'b0);
    idle_chk(1, 3, 16'h7777);

    chk("scoreboard_empty", 16'(sb.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_responder.md
Name: mem_stage_responder

Overview:
- Responder end of the EX→MEM address path: the ALU computes the LW/SW effective address and store data, and this block accepts that request and services it against an internal word-wide data memory with configurable multi-cycle latency.
- It stalls the pipeline while busy and returns load data with a one-cycle response strobe for the MEM/WB register.
- It sits in the MEM stage of the 5-stage pipeline.

Parameters:
- DEPTH_LOG2, 10, number of 16-bit words = 2**DEPTH_LOG2.
- LATENCY, 4, busy cycles per access after acceptance; legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  EX/MEM holds a LW or SW this cycle.
- req_wr  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  16  byte address from ALU address adder.
- req_wdata  in  16  store data.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  16  load data, registered.
- misaligned  out  1  pulses with resp_valid when the accepted req_addr[0] was 1.

Behaviour:
- Reset, sampled only on a rising clk edge with rst_n=0:
  - state=IDLE; cnt=0; resp_valid=0; resp_rdata=0x0000; misaligned=0.
  - Memory array is not cleared.
- Addressing:
  - Word index = req_addr[DEPTH_LOG2:1].
  - Bit 0 is ignored for the access but reported via misaligned.
  - Upper address bits are ignored, so addresses wrap modulo the memory size.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = req_valid (combinational, same cycle).
  - If req_valid, at the edge: latch req_wr, word index, req_wdata, addr[0]; cnt ← LATENCY-1; go to BUSY.
- BUSY:
  - stall=1.
  - If cnt≠0: cnt ← cnt-1.
  - If cnt=0: perform the access at the edge. For a store, mem[idx] ← wdata. For a load, resp_rdata ← mem[idx]. Go to DONE.
- DONE:
  - stall=0; resp_valid=1; misaligned = latched addr[0].
  - req_valid is ignored; it is still the same held request.
  - Next state IDLE.
- Timing, request first seen at cycle 0:
  - stall high cycles 0..LATENCY (LATENCY+1 cycles).
  - resp_valid high at cycle LATENCY+1 only.
  - LATENCY=4 gives stall cycles 0-4 and response at cycle 5.
- resp_rdata:
  - Holds its value until the next completed load.
  - Stores do not modify it.
- resp_valid and misaligned are 0 in IDLE and BUSY.
- Back-to-back: a new request in the cycle after DONE is accepted normally. No response is ever issued twice for the same request.
- Load after store to the same index returns the stored value; the write completes before DONE.
- Input changes during BUSY are ignored, because the latched copy is used.
- Reset mid-BUSY:
  - Abort with no write performed.
  - All outputs return to reset values on that edge.
  - Memory contents written by earlier completed stores are retained.
- cnt is 4 bits wide; LATENCY outside 1..15 is unsupported.

Test Plan:
1. Reset, then SW addr=0x0010 wdata=0xBEEF with LATENCY=4 → stall=1 in cycles 0-4; resp_valid=1 only in cycle 5; misaligned=0; resp_rdata stays 0x0000.
2. LW addr=0x0010 right after test 1 → resp_rdata=0xBEEF with resp_valid at cycle 5 of that request; stall low at cycle 5.
3. SW 0x1234 at 0x0021, then LW 0x0020 → load returns 0x1234; misaligned=1 on the store response and 0 on the load response.
4. Wrap (DEPTH_LOG2=10): SW 0xA5A5 at 0x0802, LW 0x0002 → 0xA5A5.
5. Reset mid-access: SW 0x5555 to 0x0040 after 0x0040 holds 0x1111; assert rst_n=0 at cycle 2 → stall=0 and resp_valid=0 after the edge; subsequent LW 0x0040 returns 0x1111.
6. req_valid held high through DONE and into the following cycle → exactly one resp_valid per request; with LATENCY=1, stall is high cycles 0-1 and the response is at cycle 2.
